// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA pattern generator slice.
//   pattern_mode_e : pattern select encoding (solid, bars, checker, gradient)
//   H_ACTIVE_DEF   : default active pixels per line
//   V_ACTIVE_DEF   : default active lines per frame
//   FRAME_W        : width of the scroll frame counter
//   bar_rot()      : channel rotation (k mod 3) for bar index k, table based
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } pattern_mode_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int FRAME_W      = 8;

    // Bar index is at most 7, so a lookup replaces a modulo-3 operator.
    function automatic logic [1:0] bar_rot(input logic [2:0] k);
        case (k)
            3'd0, 3'd3, 3'd6: bar_rot = 2'd0;
            3'd1, 3'd4, 3'd7: bar_rot = 2'd1;
            default:          bar_rot = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/vga_pixel_position.sv
// -----------------------------------------------------------------------------
// vga_pixel_position
// Tracks the current pixel position from the active-low blank strobes.
// Optional feature macro: VGA_PATTERN_SCROLL_EN (adds an 8-bit frame counter).
// Ports:
//   clk_i        pixel clock
//   rst_i        asynchronous active-high reset
//   hblank_n_i   horizontal blank, 0 = blanking
//   vblank_n_i   vertical blank, 0 = blanking
//   x_o          column of the current pixel (saturates at H_ACTIVE-1)
//   y_o          row of the current pixel (saturates at V_ACTIVE-1)
//   frame_o      frame count, wraps at 255 (VGA_PATTERN_SCROLL_EN only)
// -----------------------------------------------------------------------------
module vga_pixel_position
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hblank_n_i,
    input  logic          vblank_n_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o
`ifdef VGA_PATTERN_SCROLL_EN
    ,
    output logic [FRAME_W-1:0] frame_o
`endif
);

    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

    logic          hblank_n_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hblank_fall;

    assign hblank_fall = hblank_n_q & ~hblank_n_i;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        x_d = x_q;
        if (!hblank_n_i) begin
            x_d = '0;
        end else if (vblank_n_i && (x_q != X_MAX)) begin
            x_d = x_q + XW'(1);
        end
    end

    always_comb begin
        y_d = y_q;
        if (!vblank_n_i) begin
            y_d = '0;
        end else if (hblank_fall && (y_q != Y_MAX)) begin
            y_d = y_q + YW'(1);
        end
    end

    // Edge-detect copy resets to "blanking" so a release during an active
    // line cannot fake a falling edge; counting restarts at the next blank.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hblank_n_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            hblank_n_q <= hblank_n_i;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

`ifdef VGA_PATTERN_SCROLL_EN
    logic               vblank_n_q;
    logic [FRAME_W-1:0] frame_q;

    // Copy resets to "active" so a release mid-frame does not count a frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vblank_n_q <= 1'b1;
            frame_q    <= '0;
        end else begin
            vblank_n_q <= vblank_n_i;
            if (vblank_n_i && !vblank_n_q) begin
                frame_q <= frame_q + FRAME_W'(1);
            end
        end
    end

    assign frame_o = frame_q;
`endif

endmodule

// File: rtl/vga_pattern_generator.sv
// -----------------------------------------------------------------------------
// vga_pattern_generator
// Registered RGB test-pattern source: solid, vertical bars, checkerboard or
// horizontal gradient. The pattern mode is latched only during vertical blank.
// Optional feature macro: VGA_PATTERN_SCROLL_EN (horizontal scroll by frame).
// Ports:
//   i_clk                    pixel clock
//   i_rst                    asynchronous active-high reset
//   i_hblank_n, i_vblank_n   blank strobes from the sync generator, 0 = blank
//   i_mode                   0 solid, 1 bars, 2 checker, 3 gradient
//   i_color_a, i_color_b     colours packed {R,G,B}, sampled every pixel
//   o_r, o_g, o_b            registered colour, 0 while blanking
//   o_hblank_n, o_vblank_n   blank strobes aligned with the colour data
// -----------------------------------------------------------------------------
module vga_pattern_generator
    import vga_pkg::*;
#(
    parameter int COLOR_W   = 4,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int NUM_BARS  = 3,
    parameter int CELL_LOG2 = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_hblank_n,
    input  logic                 i_vblank_n,
    input  logic [1:0]           i_mode,
    input  logic [3*COLOR_W-1:0] i_color_a,
    input  logic [3*COLOR_W-1:0] i_color_b,
    output logic [COLOR_W-1:0]   o_r,
    output logic [COLOR_W-1:0]   o_g,
    output logic [COLOR_W-1:0]   o_b,
    output logic                 o_hblank_n,
    output logic                 o_vblank_n
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int CW = 3 * COLOR_W;
    localparam int BW = H_ACTIVE / NUM_BARS;
    localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] BW_M1    = XW'(BW - 1);
    localparam logic [2:0]    BAR_LAST = 3'(NUM_BARS - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] xs;        // pattern column, scrolled when enabled
    logic          xs_wrap;
    logic [2:0]    pre_idx;
    logic [XW-1:0] pre_cnt;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [FRAME_W-1:0] frame;
`endif

    vga_pixel_position #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .hblank_n_i (i_hblank_n),
        .vblank_n_i (i_vblank_n),
        .x_o        (x),
        .y_o        (y)
`ifdef VGA_PATTERN_SCROLL_EN
        ,
        .frame_o    (frame)
`endif
    );

`ifdef VGA_PATTERN_SCROLL_EN
    localparam int SW = ((XW > FRAME_W) ? XW : FRAME_W) + 1;

    logic [SW-1:0] x_sum;
    logic [SW-1:0] f_ext;
    logic [XW-1:0] line_start;

    // x and frame are both below H_ACTIVE, so one conditional subtract is a
    // complete modulo.
    assign x_sum      = SW'(x) + SW'(frame);
    assign xs         = (x_sum >= SW'(H_ACTIVE)) ? XW'(x_sum - SW'(H_ACTIVE)) : XW'(x_sum);
    assign f_ext      = SW'(frame);
    assign line_start = (f_ext >= SW'(H_ACTIVE)) ? XW'(f_ext - SW'(H_ACTIVE)) : XW'(f_ext);
    assign xs_wrap    = (xs == X_MAX);

    // Bar index/offset of the first pixel of a line, found by comparing
    // against constant bar edges instead of dividing.
    always_comb begin
        pre_idx = '0;
        pre_cnt = line_start;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (line_start >= XW'(k * BW)) begin
                pre_idx = 3'(k);
                pre_cnt = line_start - XW'(k * BW);
            end
        end
    end
`else
    assign xs      = x;
    assign xs_wrap = 1'b0;
    assign pre_idx = '0;
    assign pre_cnt = '0;
`endif

    // Only some position bits feed the pattern logic.
    logic unused_pos;
    assign unused_pos = ^{x, y};

    // ---------------------------------------------------------------- state
    pattern_mode_e mode_q, mode_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [XW-1:0] bar_cnt_q, bar_cnt_d;
    logic [CW-1:0] pix;
    logic          active;

    assign active = i_hblank_n & i_vblank_n;

    // Sampled on every vblank cycle, including the last one before release.
    assign mode_d = i_vblank_n ? mode_q : pattern_mode_e'(i_mode);

    // Bar counters track the column; the last bar saturates and absorbs
    // the remainder of H_ACTIVE/NUM_BARS.
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        if (!i_hblank_n) begin
            bar_idx_d = pre_idx;
            bar_cnt_d = pre_cnt;
        end else if (i_vblank_n) begin
            if (xs_wrap) begin
                bar_idx_d = '0;
                bar_cnt_d = '0;
            end else if (bar_cnt_q == BW_M1) begin
                bar_cnt_d = '0;
                if (bar_idx_q != BAR_LAST) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_cnt_d = bar_cnt_q + XW'(1);
            end
        end
    end

    // -------------------------------------------------------- pattern select
    logic [COLOR_W-1:0] a_r, a_g, a_b, grad;

    assign a_r  = i_color_a[CW-1 -: COLOR_W];
    assign a_g  = i_color_a[2*COLOR_W-1 -: COLOR_W];
    assign a_b  = i_color_a[COLOR_W-1:0];
    assign grad = xs[XW-1 -: COLOR_W];

    always_comb begin
        pix = i_color_a;
        case (mode_q)
            MODE_SOLID: pix = i_color_a;
            MODE_BARS: begin
                case (bar_rot(bar_idx_q))
                    2'd1:    pix = {a_b, a_r, a_g};
                    2'd2:    pix = {a_g, a_b, a_r};
                    default: pix = i_color_a;
                endcase
            end
            MODE_CHECKER: pix = (xs[CELL_LOG2] ^ y[CELL_LOG2]) ? i_color_b : i_color_a;
            MODE_GRADIENT: begin
                pix = {(|a_r) ? grad : {COLOR_W{1'b0}},
                       (|a_g) ? grad : {COLOR_W{1'b0}},
                       (|a_b) ? grad : {COLOR_W{1'b0}}};
            end
            default: pix = i_color_a;
        endcase
    end

    // --------------------------------------------------------- output stage
    logic [CW-1:0] rgb_q;
    logic          hblank_n_q, vblank_n_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q     <= MODE_SOLID;
            bar_idx_q  <= '0;
            bar_cnt_q  <= '0;
            rgb_q      <= '0;
            hblank_n_q <= 1'b0;
            vblank_n_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            bar_idx_q  <= bar_idx_d;
            bar_cnt_q  <= bar_cnt_d;
            // Gating with the current strobes equals gating with the
            // delayed copies, since both leave this same stage.
            rgb_q      <= active ? pix : '0;
            hblank_n_q <= i_hblank_n;
            vblank_n_q <= i_vblank_n;
        end
    end

    assign o_r        = rgb_q[CW-1 -: COLOR_W];
    assign o_g        = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign o_b        = rgb_q[COLOR_W-1:0];
    assign o_hblank_n = hblank_n_q;
    assign o_vblank_n = vblank_n_q;

endmodule

// File: tb/tb_vga_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_generator
// Directed bench for vga_pattern_generator with default parameters. Lines are
// shortened where only a few columns matter, keeping the run small.
// With VGA_PATTERN_SCROLL_EN defined the scroll section replaces the static
// position-dependent sections.
// -----------------------------------------------------------------------------
module tb_vga_pattern_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        hblank_n;
    logic        vblank_n;
    logic [1:0]  mode;
    logic [11:0] color_a;
    logic [11:0] color_b;
    logic [3:0]  r, g, b;
    logic        hb_o, vb_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] cap [0:639];
    logic [11:0] cap_blank;
    logic        cap_blank_hb;

    vga_pattern_generator dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_hblank_n (hblank_n),
        .i_vblank_n (vblank_n),
        .i_mode     (mode),
        .i_color_a  (color_a),
        .i_color_b  (color_b),
        .o_r        (r),
        .o_g        (g),
        .o_b        (b),
        .o_hblank_n (hb_o),
        .o_vblank_n (vb_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one pixel at the falling edge; on return the outputs show it.
    task automatic step(input logic hb, input logic vb);
        @(negedge clk);
        hblank_n = hb;
        vblank_n = vb;
        @(posedge clk);
        #1;
    endtask

    // Vertical blank; the new mode is presented only on its final cycle.
    task automatic frame_start(input logic [1:0] m);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        mode = m;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    // One line: n active pixels captured by column, then horizontal blank.
    task automatic run_line(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1);
            cap[i] = {r, g, b};
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
        end
        cap_blank    = {r, g, b};
        cap_blank_hb = hb_o;
    endtask

    initial begin
        rst      = 1'b1;
        hblank_n = 1'b0;
        vblank_n = 1'b0;
        mode     = 2'd0;
        color_a  = 12'hF80;
        color_b  = 12'h000;

        // ---------------- reset held with strobes toggling
        step(1'b1, 1'b1);
        check("rst_rgb_a", {r, g, b}, 12'h000);
        check("rst_hb_a", hb_o, 1'b0);
        check("rst_vb_a", vb_o, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("rst_rgb_b", {r, g, b}, 12'h000);
        check("rst_hb_b", hb_o, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check("rel_blank_hb", hb_o, 1'b0);
        step(1'b1, 1'b1);
        check("rel_first_rgb", {r, g, b}, 12'hF80);
        check("rel_first_hb", hb_o, 1'b1);
        check("rel_first_vb", vb_o, 1'b1);
        step(1'b0, 1'b1);

        // ---------------- solid
        frame_start(2'd0);
        run_line(640);
        check("solid_x0", cap[0], 12'hF80);
        check("solid_x320", cap[320], 12'hF80);
        check("solid_x639", cap[639], 12'hF80);
        check("solid_blank", cap_blank, 12'h000);
        check("solid_blank_hb", cap_blank_hb, 1'b0);

`ifndef VGA_PATTERN_SCROLL_EN
        // ---------------- bars (mode arrives on the last vblank cycle)
        color_a = 12'hF00;
        frame_start(2'd1);
        run_line(640);
        check("bars_x0", cap[0], 12'hF00);
        check("bars_x212", cap[212], 12'hF00);
        check("bars_x213", cap[213], 12'h0F0);
        check("bars_x425", cap[425], 12'h0F0);
        check("bars_x426", cap[426], 12'h00F);
        check("bars_x639", cap[639], 12'h00F);

        // ---------------- checker
        color_a = 12'hFFF;
        color_b = 12'h000;
        frame_start(2'd2);
        run_line(640);
        check("chk_x31_y0", cap[31], 12'hFFF);
        check("chk_x32_y0", cap[32], 12'h000);
        for (int l = 1; l < 32; l++) begin
            run_line(40);
        end
        run_line(40);
        check("chk_x32_y32", cap[32], 12'hFFF);
        check("chk_x31_y32", cap[31], 12'h000);

        // ---------------- mode latch
        color_a = 12'hF80;
        frame_start(2'd0);
        for (int l = 0; l < 100; l++) begin
            run_line(10);
        end
        mode = 2'd3;
        run_line(640);
        check("latch_hold_x64", cap[64], 12'hF80);
        check("latch_hold_x639", cap[639], 12'hF80);
        frame_start(2'd3);
        run_line(640);
        check("grad_x0", cap[0], 12'h000);
        check("grad_x63", cap[63], 12'h000);
        check("grad_x64", cap[64], 12'h110);
        check("grad_x639", cap[639], 12'h990);
`endif

        // ---------------- asynchronous reset mid-line
        color_a = 12'hF80;
        color_b = 12'h000;
        frame_start(2'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
        end
        check("pre_rst_rgb", {r, g, b}, 12'hF80);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_rgb", {r, g, b}, 12'h000);
        check("async_rst_hb", hb_o, 1'b0);
        check("async_rst_vb", vb_o, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        hblank_n = 1'b0;
        vblank_n = 1'b1;
        mode     = 2'd2;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // No vblank since release, so the latched mode is still solid.
        run_line(40);
        check("post_rst_x0", cap[0], 12'hF80);
        check("post_rst_x32", cap[32], 12'hF80);

`ifdef VGA_PATTERN_SCROLL_EN
        // ---------------- scroll: five frames since reset
        color_a = 12'hF00;
        for (int f = 0; f < 5; f++) begin
            frame_start(2'd1);
        end
        run_line(640);
        check("scr_x0", cap[0], 12'hF00);
        check("scr_x207", cap[207], 12'hF00);
        check("scr_x208", cap[208], 12'h0F0);
        check("scr_x420", cap[420], 12'h0F0);
        check("scr_x421", cap[421], 12'h00F);
        check("scr_x635", cap[635], 12'hF00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_generator.md
# vga_pattern_generator

Parametrised pixel-pattern source for display bring-up and validation. It sits downstream of the sync pulse generator on the pixel clock, consumes the active-low horizontal and vertical blank strobes, and tracks the pixel position internally. From that position it produces registered RGB data in one of four selectable patterns: solid, N vertical bars, checkerboard, or horizontal gradient. It replaces ad-hoc per-board colour logic, and mode changes take effect only at frame boundaries so the picture never tears.

## Interface
Parameters:
- COLOR_W, 4: bits per colour channel.
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- NUM_BARS, 3: number of vertical bars in bar mode (1 to 8).
- CELL_LOG2, 5: log2 of the checkerboard cell edge in pixels.

Ports:
- i_clk  in  1  pixel clock; all logic runs on this single clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_hblank_n  in  1  horizontal blank from the sync generator; 0 = blanking.
- i_vblank_n  in  1  vertical blank from the sync generator; 0 = blanking.
- i_mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 gradient.
- i_color_a  in  3*COLOR_W  primary colour, packed {R,G,B}.
- i_color_b  in  3*COLOR_W  secondary colour, packed {R,G,B}.
- o_r, o_g, o_b  out  COLOR_W each  registered colour data.
- o_hblank_n, o_vblank_n  out  1 each  blank strobes delayed to align with colour data.

## Operation
- Active pixel: i_hblank_n & i_vblank_n.
- x counter:
  - Increments on each active pixel.
  - Cleared while i_hblank_n=0.
  - Saturates at H_ACTIVE-1.
- y counter:
  - Increments on each falling edge of i_hblank_n (detected with a registered copy) that occurs while i_vblank_n=1.
  - Cleared while i_vblank_n=0.
  - Saturates at V_ACTIVE-1.
- Mode latch:
  - i_mode is captured into the latched mode on every cycle with i_vblank_n=0.
  - It holds while i_vblank_n=1, so a mid-frame change applies from the next frame.
  - i_color_a and i_color_b are not latched; they are sampled every pixel.
- Solid mode: colour A.
- Bar mode:
  - Bar width BW = H_ACTIVE/NUM_BARS (integer division). The last bar absorbs the remainder.
  - A bar index counter advances each time the within-bar pixel count reaches BW-1, and saturates at NUM_BARS-1. Both counters clear with x. No divider is used.
  - Bar k colour: colour A with its channels rotated right by (k mod 3). For example, k=1 gives {B,R,G}.
- Checker mode: colour A when x[CELL_LOG2] XOR y[CELL_LOG2] = 0, otherwise colour B.
- Gradient mode:
  - g = x[$clog2(H_ACTIVE)-1 -: COLOR_W].
  - Each channel outputs g if the same channel of colour A is nonzero, else 0.
- Output during blanking: colour outputs are forced to 0 whenever the delayed blank outputs indicate blanking.

## Timing
- Latency: exactly one clock from inputs to all outputs. Colour data and o_hblank_n/o_vblank_n leave the same register stage.
- Reset values:
  - o_r, o_g, o_b: 0.
  - o_hblank_n, o_vblank_n: 0.
  - x, y and bar counters: 0.
  - Latched mode: solid.
  - Frame counter: 0.
- Reset asserted mid-frame: all of the above return to their reset values immediately (asynchronous). After release, counting resumes at the next blanking interval. Data for the partial line or frame is undefined but blanking still gates colour to 0.
- A mode change and the vblank deassertion in the same cycle: the new mode is captured, because the sample is taken while i_vblank_n=0 in that cycle.
- Back-to-back frames with vblank lasting one cycle are supported.

## Configuration
- Macro: VGA_PATTERN_SCROLL_EN.
- Defined:
  - An 8-bit frame counter increments on each rising edge of i_vblank_n and wraps at 255.
  - Bar, checker and gradient modes use x' = (x + frame) mod H_ACTIVE in place of x. The bar index is derived from x' by a start-of-line preload.
  - Solid mode is unaffected.
- Undefined: no frame counter exists; the pattern is static; x' = x.

## Structure
- Shared package vga_pkg holds:
  - pattern_mode_e enum: MODE_SOLID, MODE_BARS, MODE_CHECKER, MODE_GRADIENT.
  - Default timing constants H_ACTIVE_DEF=640 and V_ACTIVE_DEF=480.
- Sub-module vga_pixel_position holds:
  - the x and y counters;
  - the hblank edge detector;
  - the frame counter, when VGA_PATTERN_SCROLL_EN is defined.
- Pattern selection and the output register live in the top module.

## Test plan
- Reset: hold i_rst high with active blanks toggling -> all outputs 0. Release -> first active pixel appears one cycle after blanks go high.
- Solid: mode 0, colour A=12'hF80 -> every active pixel reads R=F, G=8, B=0; blanking pixels read 0.
- Bars: mode 1, defaults, colour A=12'hF00 -> x 0–212 read {F,0,0}; x 213–425 read {0,F,0}; x 426–639 read {0,0,F}.
- Checker: mode 2, A=FFF, B=000 -> (x=31, y=0) is FFF; (x=32, y=0) is 000; (x=32, y=32) is FFF.
- Mode latch: switch mode 0 to mode 3 at line 100 -> the rest of the frame stays solid; the next frame shows a gradient with x=64 reading 1 and x=639 reading 9.
- Scroll: with VGA_PATTERN_SCROLL_EN defined, bar mode, after 5 frames -> the first bar boundary is at x=208.
